lcd_tx_scheduler: RTL and testbench

- Byte-level scheduler in front of the SPI byte engine driving the Nokia 5110 LCD.
- Shares the single engine between two requesters:
  - a host command port (DC=0 bytes, e.g. contrast or display-mode changes);
  - a framebuffer streamer that reads the 84x48 bitmap (6 banks x 84 columns) from a registered RAM and emits it as DC=1 data bytes.
- Inserts the set-X/set-Y address commands at frame start and wherever a host command interrupts a frame.

---
 rtl/lcd_tx_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_lcd_tx_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_tx_scheduler.sv
// Byte scheduler sharing one SPI byte engine between host commands and a 6x84 framebuffer stream.
// Optional LCD_AUTO_REFRESH_EN adds an idle down-counter that re-requests a frame every REFRESH_DIV cycles.
module lcd_tx_scheduler #(
  parameter int COLS   = 84,
  parameter int BANKS  = 6,
  parameter int ADDR_W = 9
`ifdef LCD_AUTO_REFRESH_EN
  ,
  parameter logic [23:0] REFRESH_DIV = 24'd5_000_000
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        cmd_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              frame_req,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [7:0]        fb_data,
  output logic [7:0]        tx_data,
  output logic              tx_dc,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              frame_done
);

  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_SETX,
    S_SETY,
    S_FETCH,
    S_DATA
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_dc_q, tx_dc_d;
  logic                tx_valid_q, tx_valid_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic [ADDR_W-1:0]   fb_addr_q, fb_addr_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic                pend_q, pend_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic                pend_set;
  logic                last_xfer;

`ifdef LCD_AUTO_REFRESH_EN
  logic [23:0]         refresh_cnt_q, refresh_cnt_d;
  logic                refresh_hit;

  assign refresh_hit = (state_q == S_IDLE) && (refresh_cnt_q == 24'd1);
  assign pend_set    = frame_req | refresh_hit;
`else
  assign pend_set    = frame_req;
`endif

  always_comb begin
    state_d      = state_q;
    tx_data_d    = tx_data_q;
    tx_dc_d      = tx_dc_q;
    tx_valid_d   = tx_valid_q;
    cmd_ready_d  = 1'b0;
    fb_addr_d    = fb_addr_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    pend_d       = pend_q | pend_set;
    col_d        = col_q;
    bank_d       = bank_q;
    last_xfer    = 1'b0;

    // Each byte state loads its byte while tx_valid is low, then waits for
    // the transfer; dropping tx_valid on transfer gives the mandatory gap.
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_CMD;
        end else if (pend_q) begin
          state_d   = S_SETX;
          col_d     = '0;
          bank_d    = '0;
          fb_addr_d = '0;
          busy_d    = 1'b1;
          pend_d    = frame_req;
        end
      end
      S_CMD: begin
        if (!tx_valid_q) begin
          tx_data_d   = cmd_data;
          tx_dc_d     = 1'b0;
          tx_valid_d  = 1'b1;
          cmd_ready_d = 1'b1;
        end else if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = busy_q ? S_SETX : S_IDLE;
        end
      end
      S_SETX: begin
        if (!tx_valid_q) begin
          tx_data_d  = 8'h80 | 8'(col_q);
          tx_dc_d    = 1'b0;
          tx_valid_d = 1'b1;
        end else if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = S_SETY;
        end
      end
      S_SETY: begin
        if (!tx_valid_q) begin
          tx_data_d  = 8'h40 | 8'(bank_q);
          tx_dc_d    = 1'b0;
          tx_valid_d = 1'b1;
        end else if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_DATA;
      end
      S_DATA: begin
        if (!tx_valid_q) begin
          tx_data_d  = fb_data;
          tx_dc_d    = 1'b1;
          tx_valid_d = 1'b1;
        end else if (tx_ready) begin
          tx_valid_d = 1'b0;
          // fb_addr runs linearly, so it always equals bank*COLS+col
          if (col_q != COL_W'(COLS - 1)) begin
            col_d     = col_q + COL_W'(1);
            fb_addr_d = fb_addr_q + ADDR_W'(1);
            state_d   = S_FETCH;
          end else if (bank_q != BANK_W'(BANKS - 1)) begin
            col_d     = '0;
            bank_d    = bank_q + BANK_W'(1);
            fb_addr_d = fb_addr_q + ADDR_W'(1);
            state_d   = cmd_valid ? S_CMD : S_FETCH;
          end else begin
            col_d        = '0;
            bank_d       = '0;
            fb_addr_d    = '0;
            busy_d       = 1'b0;
            frame_done_d = 1'b1;
            last_xfer    = 1'b1;
            state_d      = S_IDLE;
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
  end

`ifdef LCD_AUTO_REFRESH_EN
  always_comb begin
    refresh_cnt_d = refresh_cnt_q;
    if ((state_q == S_IDLE) && (refresh_cnt_q != 24'd0)) begin
      refresh_cnt_d = refresh_cnt_q - 24'd1;
    end
    if (frame_req || last_xfer) begin
      refresh_cnt_d = REFRESH_DIV;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt_q <= REFRESH_DIV;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tx_data_q    <= 8'h00;
      tx_dc_q      <= 1'b0;
      tx_valid_q   <= 1'b0;
      cmd_ready_q  <= 1'b0;
      fb_addr_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      pend_q       <= 1'b0;
      col_q        <= '0;
      bank_q       <= '0;
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      tx_dc_q      <= tx_dc_d;
      tx_valid_q   <= tx_valid_d;
      cmd_ready_q  <= cmd_ready_d;
      fb_addr_q    <= fb_addr_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      pend_q       <= pend_d;
      col_q        <= col_d;
      bank_q       <= bank_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_dc      = tx_dc_q;
  assign tx_valid   = tx_valid_q;
  assign cmd_ready  = cmd_ready_q;
  assign fb_addr    = fb_addr_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_tx_scheduler.sv
// Bench for lcd_tx_scheduler: expected byte stream built from frame/command rules, checked per transfer.
module tb_lcd_tx_scheduler;
  localparam int COLS  = 84;
  localparam int BANKS = 6;
  localparam int FRAME = COLS * BANKS;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       frame_req;
  logic [8:0] fb_addr;
  logic [7:0] fb_data = 8'h00;
  logic [7:0] tx_data;
  logic       tx_dc;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       frame_done;

  always #5 clk = ~clk;

  lcd_tx_scheduler dut (
    .clk(clk), .rst(rst),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .frame_req(frame_req),
    .fb_addr(fb_addr), .fb_data(fb_data),
    .tx_data(tx_data), .tx_dc(tx_dc), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_done(frame_done)
  );

  // registered framebuffer RAM whose contents equal the low address byte
  always @(posedge clk) fb_data <= fb_addr[7:0];

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  logic [8:0] exp_q[$];
  logic [8:0] rx_log[$];
  int fd_cnt = 0;
  int cr_cnt = 0;
  int data_cnt = 0;

  // expected frame: address commands, then linear data; a command that
  // interrupts bank ib is followed by readdressing to the start of bank ib+1
  task automatic push_frame(input int ib, input logic [7:0] c);
    exp_q.push_back({1'b0, 8'h80});
    exp_q.push_back({1'b0, 8'h40});
    for (int a = 0; a < FRAME; a++) begin
      if (ib >= 0 && a == (ib + 1) * COLS) begin
        exp_q.push_back({1'b0, c});
        exp_q.push_back({1'b0, 8'h80});
        exp_q.push_back({1'b0, 8'h40 | 8'(a / COLS)});
      end
      exp_q.push_back({1'b1, 8'(a)});
    end
  endtask

  logic       prev_v = 1'b0;
  logic       prev_r = 1'b0;
  logic [8:0] prev_b = 9'h0;

  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        check("hold_valid", tx_valid, 1);
        check("hold_byte", {tx_dc, tx_data}, prev_b);
      end else if (prev_v && prev_r) begin
        check("post_xfer_gap", tx_valid, 0);
      end
      if (tx_valid && tx_dc) check("busy_during_data", busy, 1);
      if (tx_valid && tx_ready) begin
        rx_log.push_back({tx_dc, tx_data});
        if (tx_dc) data_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_byte: got %0h want none", {tx_dc, tx_data});
        end else begin
          check("byte", {tx_dc, tx_data}, exp_q.pop_front());
        end
      end
      if (frame_done) fd_cnt++;
      if (cmd_ready) cr_cnt++;
      prev_v = tx_valid;
      prev_r = tx_ready;
      prev_b = {tx_dc, tx_data};
    end
  end

  task automatic pulse_frame_req();
    @(posedge clk); #1 frame_req = 1'b1;
    @(posedge clk); #1 frame_req = 1'b0;
  endtask

  task automatic wait_fd(input int target);
    int n = 0;
    while (fd_cnt < target && n < 5000) begin @(negedge clk); n++; end
    check("frame_done_reached", 32'(fd_cnt >= target), 1);
    repeat (6) @(negedge clk);
    check("frame_done_once", fd_cnt, target);
  endtask

  task automatic wait_data(input int target);
    int n = 0;
    while (data_cnt < target && n < 5000) begin @(negedge clk); n++; end
    check("data_count_reached", 32'(data_cnt >= target), 1);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    int n = 0;
    @(posedge clk); #1 cmd_data = c; cmd_valid = 1'b1;
    while (!cmd_ready && n < 2000) begin @(negedge clk); n++; end
    check("cmd_ready_seen", cmd_ready, 1);
    @(posedge clk); #1 cmd_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_valid"}, tx_valid, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_tx_dc"}, tx_dc, 0);
    check({tag, "_cmd_ready"}, cmd_ready, 0);
    check({tag, "_fb_addr"}, fb_addr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd_base;
    int cr_base;
    rst = 1'b1; cmd_valid = 1'b0; cmd_data = 8'h00; frame_req = 1'b0; tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    // single host command outside a frame
    rx_log.delete();
    exp_q.push_back({1'b0, 8'h21});
    send_cmd(8'h21);
    repeat (8) @(negedge clk);
    check("cmd_ready_pulses", cr_cnt, 1);
    check("cmd_busy", busy, 0);
    check("cmd_log_size", rx_log.size(), 1);
    check("cmd_byte_lit", rx_log[0], 9'h021);
    check("cmd_drained", exp_q.size(), 0);

    // plain frame
    rx_log.delete(); data_cnt = 0;
    push_frame(-1, 8'h00);
    pulse_frame_req();
    wait_fd(1);
    check("frame_busy_after", busy, 0);
    check("frame_log_size", rx_log.size(), FRAME + 2);
    check("frame_setx_lit", rx_log[0], 9'h080);
    check("frame_sety_lit", rx_log[1], 9'h040);
    check("frame_wrap_lit", rx_log[2 + 256], 9'h100);
    check("frame_last_lit", rx_log[FRAME + 1], 9'h1F7);
    check("frame_drained", exp_q.size(), 0);

    // command arriving during byte 10 of bank 2
    rx_log.delete(); data_cnt = 0;
    cr_base = cr_cnt;
    push_frame(2, 8'h0C);
    pulse_frame_req();
    wait_data(2 * COLS + 11);
    send_cmd(8'h0C);
    wait_fd(2);
    check("intr_cmd_ready", cr_cnt, cr_base + 1);
    check("intr_cmd_lit", rx_log[2 + 252], 9'h00C);
    check("intr_setx_lit", rx_log[2 + 253], 9'h080);
    check("intr_sety_lit", rx_log[2 + 254], 9'h043);
    check("intr_resume_lit", rx_log[2 + 255], 9'h1FC);
    check("intr_drained", exp_q.size(), 0);

    // 20-cycle stall mid-frame
    rx_log.delete(); data_cnt = 0;
    push_frame(-1, 8'h00);
    pulse_frame_req();
    wait_data(50);
    @(posedge clk); #1 tx_ready = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    check("stall_valid_held", tx_valid, 1);
    check("stall_dc_held", tx_dc, 1);
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_fd(3);
    check("stall_log_size", rx_log.size(), FRAME + 2);
    check("stall_drained", exp_q.size(), 0);

    // reset in bank 4, then a fresh frame
    rx_log.delete(); data_cnt = 0;
    push_frame(-1, 8'h00);
    pulse_frame_req();
    wait_data(4 * COLS + 5);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midreset");
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    fd_base = fd_cnt;
    rx_log.delete();
    repeat (20) @(negedge clk);
    check("no_pend_after_reset", rx_log.size(), 0);
    data_cnt = 0;
    push_frame(-1, 8'h00);
    pulse_frame_req();
    wait_fd(fd_base + 1);
    check("restart_setx_lit", rx_log[0], 9'h080);
    check("restart_sety_lit", rx_log[1], 9'h040);
    check("restart_first_lit", rx_log[2], 9'h100);
    check("restart_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
